hid_report_uart_rx: RTL and testbench

// - Receive end of the HID report stream the USB-host CPU firmware sends on its UART TX (8N1, 1 Mb/s at 48 MHz).
// - Parses framed reports and drives registered keyboard, mouse and connection outputs for the rest of the bridge.
// - Sits beside the USB host SoC; uart_rxd connects to cpu_uart_tx.
// - Frame: 0xA5 | TYPE | LEN | PAYLOAD[LEN] | CHK.
// - CHK is chosen so that TYPE+LEN+sum(PAYLOAD)+CHK == 0 mod 256.

---
 rtl/hid_report_pkg.sv | 35 +++
 rtl/uart_rx_byte.sv | 99 +++++++++
 rtl/hid_report_uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_hid_report_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hid_report_pkg.sv
// Shared constants, parser/receiver state types and frame helpers for the HID report UART receiver.
package hid_report_pkg;

  localparam int unsigned BAUD_DIV     = 48;
  localparam int unsigned TIMEOUT_BITS = 32;
  localparam int unsigned MAX_LEN      = 8;
  localparam int unsigned IDX_W        = $clog2(MAX_LEN);
  localparam int unsigned CNT_W        = $clog2(BAUD_DIV);
  localparam int unsigned TIMEOUT_CYC  = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TMO_W        = $clog2(TIMEOUT_CYC);

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] TYPE_KBD    = 8'h01;
  localparam logic [7:0] TYPE_MOUSE  = 8'h02;
  localparam logic [7:0] TYPE_STATUS = 8'h03;
  localparam logic [7:0] LEN_KBD     = 8'd7;
  localparam logic [7:0] LEN_MOUSE   = 8'd7;
  localparam logic [7:0] LEN_STATUS  = 8'd1;

  typedef enum logic [2:0] {HUNT, TYPE, LEN, PAYLOAD, CHK} parse_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // A LEN is accepted only if it matches its TYPE's fixed length and fits the buffer.
  function automatic logic len_ok(input logic [7:0] t, input logic [7:0] l);
    logic ok;
    case (t)
      TYPE_KBD:    ok = (l == LEN_KBD);
      TYPE_MOUSE:  ok = (l == LEN_MOUSE);
      TYPE_STATUS: ok = (l == LEN_STATUS);
      default:     ok = 1'b0;
    endcase
    return ok && (l <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: double-flop sync, mid-bit sampling, start-glitch rejection, stop-bit check.
module uart_rx_byte
  import hid_report_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  rx_state_e        state_q, state_d;
  logic             meta_q, sync_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d, byte_q, byte_d;
  logic             vld_q, vld_d, ferr_q, ferr_d, busy_q;

  wire half_tick = (cnt_q == CNT_W'(BAUD_DIV / 2 - 1));
  wire full_tick = (cnt_q == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= RX_IDLE;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= rxd_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != RX_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !sync_q) state_d = RX_START;
      RX_START: if (half_tick) state_d = sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (full_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      RX_START: if (half_tick) cnt_d = '0;
      RX_DATA: if (full_tick) begin
        cnt_d   = '0;
        shift_d = {sync_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      RX_STOP: if (full_tick) begin
        cnt_d = '0;
        if (sync_q) begin
          vld_d  = 1'b1;
          byte_d = shift_q;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign byte_o      = byte_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;

endmodule

// File: rtl/hid_report_uart_rx.sv
// Parses framed HID reports from the host CPU UART and drives registered keyboard/mouse/status outputs.
module hid_report_uart_rx
  import hid_report_pkg::*;
(
  input  logic        clk_48m,
  input  logic        rstn,
  input  logic        uart_rxd,
  output logic        keyboard_connected,
  output logic        mouse_connected,
  output logic [7:0]  keyboard_modifiers,
  output logic [47:0] keyboard_keycodes,
  output logic [7:0]  mouse_buttons,
  output logic [31:0] mouse_x,
  output logic [31:0] mouse_y,
  output logic [31:0] mouse_wheel,
  output logic        report_stb,
  output logic [7:0]  err_cnt
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr, rx_busy;

  uart_rx_byte u_rx (
    .clk_i       (clk_48m),
    .rstn_i      (rstn),
    .rxd_i       (uart_rxd),
    .byte_o      (rx_byte),
    .byte_vld_o  (rx_vld),
    .frame_err_o (rx_ferr),
    .busy_o      (rx_busy)
  );

  parse_state_e     state_q, state_d;
  logic [7:0]       type_q, type_d, len_q, len_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       pay_q [MAX_LEN];
  logic             pay_we, commit, err_evt, tmo_fire;

  logic        kconn_q, kconn_d, mconn_q, mconn_d, stb_q, stb_d;
  logic [7:0]  mods_q, mods_d, btn_q, btn_d, err_q, err_d;
  logic [47:0] keys_q, keys_d;
  logic [31:0] x_q, x_d, y_q, y_d, whl_q, whl_d;

  always_ff @(posedge clk_48m) begin
    if (!rstn) begin
      state_q <= HUNT;
      type_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      kconn_q <= 1'b0;
      mconn_q <= 1'b0;
      stb_q   <= 1'b0;
      mods_q  <= '0;
      btn_q   <= '0;
      err_q   <= '0;
      keys_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      whl_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      kconn_q <= kconn_d;
      mconn_q <= mconn_d;
      stb_q   <= stb_d;
      mods_q  <= mods_d;
      btn_q   <= btn_d;
      err_q   <= err_d;
      keys_q  <= keys_d;
      x_q     <= x_d;
      y_q     <= y_d;
      whl_q   <= whl_d;
    end
  end

  always_ff @(posedge clk_48m) begin
    if (pay_we) pay_q[idx_q] <= rx_byte;
  end

  // Frame parser; the inter-byte timer only runs while a frame is open and the line is quiet.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    len_d    = len_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    pay_we   = 1'b0;
    commit   = 1'b0;
    err_evt  = 1'b0;
    tmo_fire = (state_q != HUNT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    tmo_d    = (state_q == HUNT || rx_busy || rx_vld) ? '0 : tmo_q + TMO_W'(1);
    if (rx_ferr || tmo_fire) begin
      err_evt = 1'b1;
      state_d = HUNT;
    end else if (rx_vld) begin
      case (state_q)
        HUNT: if (rx_byte == SYNC_BYTE) state_d = TYPE;
        TYPE: begin
          type_d  = rx_byte;
          sum_d   = rx_byte;
          state_d = LEN;
        end
        LEN: begin
          len_d = rx_byte;
          sum_d = sum_q + rx_byte;
          idx_d = '0;
          if (!len_ok(type_q, rx_byte)) begin
            err_evt = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = (rx_byte == 8'd0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          pay_we = 1'b1;
          sum_d  = sum_q + rx_byte;
          idx_d  = idx_q + IDX_W'(1);
          if (8'(idx_q) == len_q - 8'd1) state_d = CHK;
        end
        CHK: begin
          if (8'(sum_q + rx_byte) == 8'd0) commit = 1'b1;
          else err_evt = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    kconn_d = kconn_q;
    mconn_d = mconn_q;
    mods_d  = mods_q;
    keys_d  = keys_q;
    btn_d   = btn_q;
    x_d     = x_q;
    y_d     = y_q;
    whl_d   = whl_q;
    stb_d   = commit;
    err_d   = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    if (commit) begin
      case (type_q)
        TYPE_KBD: begin
          mods_d = pay_q[0];
          keys_d = {pay_q[6], pay_q[5], pay_q[4], pay_q[3], pay_q[2], pay_q[1]};
        end
        TYPE_MOUSE: begin
          btn_d = pay_q[0];
          x_d   = x_q   + {{16{pay_q[2][7]}}, pay_q[2], pay_q[1]};
          y_d   = y_q   + {{16{pay_q[4][7]}}, pay_q[4], pay_q[3]};
          whl_d = whl_q + {{16{pay_q[6][7]}}, pay_q[6], pay_q[5]};
        end
        TYPE_STATUS: begin
          kconn_d = pay_q[0][0];
          mconn_d = pay_q[0][1];
          if (kconn_q && !pay_q[0][0]) begin
            mods_d = '0;
            keys_d = '0;
          end
          if (mconn_q && !pay_q[0][1]) begin
            btn_d = '0;
            x_d   = '0;
            y_d   = '0;
            whl_d = '0;
          end
        end
        default: stb_d = commit;
      endcase
    end
  end

  assign keyboard_connected = kconn_q;
  assign mouse_connected    = mconn_q;
  assign keyboard_modifiers = mods_q;
  assign keyboard_keycodes  = keys_q;
  assign mouse_buttons      = btn_q;
  assign mouse_x            = x_q;
  assign mouse_y            = y_q;
  assign mouse_wheel        = whl_q;
  assign report_stb         = stb_q;
  assign err_cnt            = err_q;

endmodule

// File: tb/tb_hid_report_uart_rx.sv
// Directed bench for hid_report_uart_rx: serialises frames on uart_rxd and checks committed outputs.
module tb_hid_report_uart_rx;

  localparam int BIT = 48;

  logic        clk_48m = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        keyboard_connected, mouse_connected, report_stb;
  logic [7:0]  keyboard_modifiers, mouse_buttons, err_cnt;
  logic [47:0] keyboard_keycodes;
  logic [31:0] mouse_x, mouse_y, mouse_wheel;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0;
  int s0;

  hid_report_uart_rx dut (
    .clk_48m            (clk_48m),
    .rstn               (rstn),
    .uart_rxd           (uart_rxd),
    .keyboard_connected (keyboard_connected),
    .mouse_connected    (mouse_connected),
    .keyboard_modifiers (keyboard_modifiers),
    .keyboard_keycodes  (keyboard_keycodes),
    .mouse_buttons      (mouse_buttons),
    .mouse_x            (mouse_x),
    .mouse_y            (mouse_y),
    .mouse_wheel        (mouse_wheel),
    .report_stb         (report_stb),
    .err_cnt            (err_cnt)
  );

  always #10 clk_48m = ~clk_48m;

  always @(negedge clk_48m) if (report_stb === 1'b1) stb_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int bits);
    uart_rxd = 1'b1;
    repeat (bits * BIT) @(negedge clk_48m);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk_48m);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk_48m);
    end
    uart_rxd = stop;
    repeat (BIT) @(negedge clk_48m);
    uart_rxd = 1'b1;
  endtask

  // Payload byte i at p[8i+7:8i]; chk_add perturbs the correct checksum.
  task automatic send_frame(input logic [7:0] t, input logic [7:0] l, input logic [63:0] p,
                            input logic [7:0] chk_add);
    logic [7:0] s;
    s = t + l;
    send_byte(8'hA5, 1'b1);
    send_byte(t, 1'b1);
    send_byte(l, 1'b1);
    for (int i = 0; i < int'(l); i++) begin
      s = s + p[8*i +: 8];
      send_byte(p[8*i +: 8], 1'b1);
    end
    send_byte(8'(8'd0 - s) + chk_add, 1'b1);
    repeat (2) @(negedge clk_48m);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (4) @(negedge clk_48m);
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err got %h exp 00", err_cnt); end
    n_cmp++; if (report_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got %b exp 0", report_stb); end
    n_cmp++; if ({keyboard_connected, mouse_connected} !== 2'b00) begin n_bad++; $display("FAIL reset_conn got %b%b exp 00", keyboard_connected, mouse_connected); end
    n_cmp++; if (keyboard_keycodes !== 48'd0) begin n_bad++; $display("FAIL reset_keys got %h exp 0", keyboard_keycodes); end
    n_cmp++; if (mouse_x !== 32'd0) begin n_bad++; $display("FAIL reset_x got %h exp 0", mouse_x); end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_kbd;
    s0 = stb_cnt;
    send_frame(8'h01, 8'd7, 64'h0000_0000_0005_0402, 8'd0);
    n_cmp++; if (keyboard_modifiers !== 8'h02) begin n_bad++; $display("FAIL kbd_mods got %h exp 02", keyboard_modifiers); end
    n_cmp++; if (keyboard_keycodes !== 48'h000000000504) begin n_bad++; $display("FAIL kbd_keys got %h exp 000000000504", keyboard_keycodes); end
    n_cmp++; if (stb_cnt - s0 !== 1) begin n_bad++; $display("FAIL kbd_stb got %0d pulses exp 1", stb_cnt - s0); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL kbd_err got %h exp 00", err_cnt); end
  endtask

  task automatic test_mouse;
    send_frame(8'h02, 8'd7, 64'h0000_01FF_FD00_0501, 8'd0);
    n_cmp++; if (mouse_x !== 32'd5) begin n_bad++; $display("FAIL mouse_x1 got %h exp 5", mouse_x); end
    n_cmp++; if (mouse_y !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL mouse_y1 got %h exp FFFFFFFD", mouse_y); end
    send_frame(8'h02, 8'd7, 64'h0000_01FF_FD00_0501, 8'd0);
    n_cmp++; if (mouse_x !== 32'd10) begin n_bad++; $display("FAIL mouse_x2 got %h exp 0000000A", mouse_x); end
    n_cmp++; if (mouse_y !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mouse_y2 got %h exp FFFFFFFA", mouse_y); end
    n_cmp++; if (mouse_wheel !== 32'd2) begin n_bad++; $display("FAIL mouse_wheel got %h exp 2", mouse_wheel); end
    n_cmp++; if (mouse_buttons !== 8'h01) begin n_bad++; $display("FAIL mouse_btn got %h exp 01", mouse_buttons); end
    n_cmp++; if (keyboard_modifiers !== 8'h02) begin n_bad++; $display("FAIL mouse_kbd_kept got %h exp 02", keyboard_modifiers); end
  endtask

  task automatic test_bad_chk;
    s0 = stb_cnt;
    send_frame(8'h01, 8'd7, 64'h11, 8'd1);
    n_cmp++; if (keyboard_modifiers !== 8'h02) begin n_bad++; $display("FAIL badchk_mods got %h exp 02", keyboard_modifiers); end
    n_cmp++; if (stb_cnt - s0 !== 0) begin n_bad++; $display("FAIL badchk_stb got %0d pulses exp 0", stb_cnt - s0); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL badchk_err got %h exp 01", err_cnt); end
    s0 = stb_cnt;
    send_frame(8'h01, 8'd7, 64'h0620, 8'd0);
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes} !== {8'h20, 48'h06}) begin n_bad++; $display("FAIL badchk_next got %h/%h exp 20/6", keyboard_modifiers, keyboard_keycodes); end
    n_cmp++; if (stb_cnt - s0 !== 1 || err_cnt !== 8'd1) begin n_bad++; $display("FAIL badchk_next_stb got %0d/%h exp 1/01", stb_cnt - s0, err_cnt); end
  endtask

  task automatic test_framing;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b0);
    idle(2);
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL ferr_err got %h exp 02", err_cnt); end
    n_cmp++; if (keyboard_modifiers !== 8'h20) begin n_bad++; $display("FAIL ferr_mods got %h exp 20", keyboard_modifiers); end
    send_frame(8'h01, 8'd7, 64'h0733, 8'd0);
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes} !== {8'h33, 48'h07}) begin n_bad++; $display("FAIL ferr_next got %h/%h exp 33/7", keyboard_modifiers, keyboard_keycodes); end
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL ferr_next_err got %h exp 02", err_cnt); end
  endtask

  task automatic test_status;
    send_frame(8'h03, 8'd1, 64'h03, 8'd0);
    n_cmp++; if ({keyboard_connected, mouse_connected} !== 2'b11) begin n_bad++; $display("FAIL stat_on got %b%b exp 11", keyboard_connected, mouse_connected); end
    send_frame(8'h03, 8'd1, 64'h01, 8'd0);
    n_cmp++; if ({keyboard_connected, mouse_connected} !== 2'b10) begin n_bad++; $display("FAIL stat_off got %b%b exp 10", keyboard_connected, mouse_connected); end
    n_cmp++; if ({mouse_x, mouse_y, mouse_wheel, mouse_buttons} !== 104'd0) begin n_bad++; $display("FAIL stat_mouse_clr got %h %h %h %h exp 0", mouse_x, mouse_y, mouse_wheel, mouse_buttons); end
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes} !== {8'h33, 48'h07}) begin n_bad++; $display("FAIL stat_kbd_kept got %h/%h exp 33/7", keyboard_modifiers, keyboard_keycodes); end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    idle(40);
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL tmo_err got %h exp 03", err_cnt); end
    send_frame(8'h01, 8'd7, 64'h0044, 8'd0);
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes} !== {8'h44, 48'h0}) begin n_bad++; $display("FAIL tmo_next got %h/%h exp 44/0", keyboard_modifiers, keyboard_keycodes); end
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL tmo_next_err got %h exp 03", err_cnt); end
  endtask

  task automatic test_a5_payload;
    send_frame(8'h01, 8'd7, 64'hA5A5, 8'd0);
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes} !== {8'hA5, 48'hA5}) begin n_bad++; $display("FAIL a5_data got %h/%h exp A5/A5", keyboard_modifiers, keyboard_keycodes); end
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL a5_err got %h exp 03", err_cnt); end
  endtask

  task automatic test_reset_mid;
    send_frame(8'h02, 8'd7, 64'h0000_01FF_FD00_0501, 8'd0);
    n_cmp++; if (mouse_x !== 32'd5) begin n_bad++; $display("FAIL rst_pre_x got %h exp 5", mouse_x); end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h02, 1'b1);
    rstn = 1'b0;
    repeat (3) @(negedge clk_48m);
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes, keyboard_connected} !== 57'd0) begin n_bad++; $display("FAIL rst_kbd got %h/%h/%b exp 0", keyboard_modifiers, keyboard_keycodes, keyboard_connected); end
    n_cmp++; if ({mouse_x, mouse_y, mouse_wheel, mouse_buttons} !== 104'd0) begin n_bad++; $display("FAIL rst_mouse got %h %h %h %h exp 0", mouse_x, mouse_y, mouse_wheel, mouse_buttons); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err got %h exp 00", err_cnt); end
    rstn = 1'b1;
    idle(1);
    s0 = stb_cnt;
    send_frame(8'h01, 8'd7, 64'h0155, 8'd0);
    n_cmp++; if ({keyboard_modifiers, keyboard_keycodes} !== {8'h55, 48'h01}) begin n_bad++; $display("FAIL rst_next got %h/%h exp 55/1", keyboard_modifiers, keyboard_keycodes); end
    n_cmp++; if (stb_cnt - s0 !== 1 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_next_stb got %0d/%h exp 1/00", stb_cnt - s0, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_kbd();
    test_mouse();
    test_bad_chk();
    test_framing();
    test_status();
    test_timeout();
    test_a5_payload();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
